// File: rtl/ps2_pkg.sv
// Shared constants, types and key-mapping helper for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] SC_EXT         = 8'hE0;
    localparam logic [7:0] SC_BRK         = 8'hF0;
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
    localparam logic [7:0] SC_W           = 8'h1D;
    localparam logic [7:0] SC_S           = 8'h1B;
    localparam logic [7:0] SC_A           = 8'h1C;
    localparam logic [7:0] SC_D           = 8'h23;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } key_map_t;

    // Arrow keys only count behind an E0 prefix; WASD only without one.
    function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.dir = DIR_UP;
        if (ext) begin
            case (code)
                SC_ARROW_UP:    m.dir = DIR_UP;
                SC_ARROW_DOWN:  m.dir = DIR_DOWN;
                SC_ARROW_LEFT:  m.dir = DIR_LEFT;
                SC_ARROW_RIGHT: m.dir = DIR_RIGHT;
                default:        m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:    m.dir = DIR_UP;
                SC_S:    m.dir = DIR_DOWN;
                SC_A:    m.dir = DIR_LEFT;
                SC_D:    m.dir = DIR_RIGHT;
                default: m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises both PS/2 pins, de-glitches the clock and emits a one-cycle
// strobe on each falling edge of the filtered clock.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fall,
    output logic o_data
);

    localparam int unsigned CW = $clog2(FILTER_LEN);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          r_fall;

    // The filtered level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_filt      <= 1'b0;
            r_cnt       <= '0;
            r_fall      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_fall      <= 1'b0;
            if (r_clk_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_sync[1];
                r_cnt  <= '0;
                r_fall <= r_filt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_fall = r_fall;
    assign o_data = r_data_sync[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deframes device-to-host frames and decodes
// make/break/E0 sequences into the game's direction code.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] dir,
    output logic       dir_held,
    output logic       byte_valid,
    output logic [7:0] scancode,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    logic         w_fall;
    logic         w_data;
    logic         w_good;
    key_map_t     w_key;
    logic [3:0]   w_held_nxt;

    frame_state_t r_state;
    logic [9:0]   r_shift;
    logic [3:0]   r_bitcnt;
    logic [TW-1:0] r_idle;
    logic [3:0]   r_held;
    logic         r_ext;
    logic         r_brk;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_fall     (w_fall),
        .o_data     (w_data)
    );

    // Odd parity over data+parity, stop bit must be high.
    assign w_good = (^r_shift[8:0]) && r_shift[9];
    assign w_key  = map_key(r_shift[7:0], r_ext);

    always_comb begin
        w_held_nxt = r_held;
        if (w_key.hit) begin
            w_held_nxt[w_key.dir] = ~r_brk;
        end
    end

    // Frame FSM plus decode; r_idle counts cycles since the last fall, the fall cycle being cycle 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_idle     <= '0;
            r_held     <= '0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            dir        <= '0;
            dir_held   <= 1'b0;
            byte_valid <= 1'b0;
            scancode   <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !w_data) begin
                        r_bitcnt <= '0;
                        r_idle   <= TW'(1);
                        r_state  <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (w_fall) begin
                        r_shift  <= {w_data, r_shift[9:1]};
                        r_idle   <= TW'(1);
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 4'd9) begin
                            r_state <= ST_CHECK;
                        end
                    end else if (r_idle == TW'(TIMEOUT_CYC - 1)) begin
                        frame_err <= 1'b1;
                        r_ext     <= 1'b0;
                        r_brk     <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_state <= ST_IDLE;
                    if (w_good) begin
                        byte_valid <= 1'b1;
                        scancode   <= r_shift[7:0];
                        if (r_shift[7:0] == SC_EXT) begin
                            r_ext <= 1'b1;
                        end else if (r_shift[7:0] == SC_BRK) begin
                            r_brk <= 1'b1;
                        end else begin
                            r_ext    <= 1'b0;
                            r_brk    <= 1'b0;
                            r_held   <= w_held_nxt;
                            dir_held <= |w_held_nxt;
                            if (w_key.hit && !r_brk) begin
                                dir <= w_key.dir;
                            end
                        end
                    end else begin
                        frame_err <= 1'b1;
                        r_ext     <= 1'b0;
                        r_brk     <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
